tl_ul_master: RTL and testbench
===============================

# tl_ul_master

Single-outstanding TileLink-UL initiator that converts simple host commands (read/write, 4-bit address, byte mask, 32-bit data) into channel-A requests and collects the channel-D response. It sits between the test/host sequencer and the register-bus slave that fronts the CORDIC register file, driving the opposite end of that slave's A/D channels. It includes a response timeout so a hung slave cannot stall the host.

## Interface
Parameters:
- TIMEOUT, 255 — cycles allowed from entering A_SEND until the D beat; range 1..255, 8-bit counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  host command valid
- req_ready  out  1  high in IDLE only
- req_write  in  1  1 = write, 0 = read
- req_addr  in  4  register address
- req_mask  in  4  byte enables
- req_wdata  in  32  write data
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  timeout or opcode mismatch
- a_valid  out  1  channel-A valid
- a_ready  in  1  slave ready
- a_opcode  out  4  0 PutFullData, 1 PutPartialData, 4 Get
- a_mask  out  4  byte mask
- a_address  out  4  address
- a_data  out  32  write data; 0 for Get
- d_valid  in  1  channel-D valid
- d_ready  out  1  initiator ready for D
- d_opcode  in  4  0 AccessAck, 1 AccessAckData
- d_data  in  32  response data

## Operation
- FSM states: IDLE, A_SEND, D_WAIT, RSP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid at the edge, latch the command and go to A_SEND. Opcode: write with mask=4'hF → 0; write with any other mask → 1; read → 4. For reads, a_mask=req_mask and a_data=0.
- A_SEND: a_valid=1. A_* outputs come from registers and stay stable until the handshake. On a_valid&&a_ready at the edge, go to D_WAIT.
- D_WAIT: d_ready=1. On d_valid at the edge, capture the response and go to RSP.
  - Read with d_opcode=1: rsp_rdata=d_data, err=0.
  - Write with d_opcode=0: rsp_rdata=0, err=0.
  - Any other pairing: err=1, rsp_rdata=0.
- RSP: rsp_valid=1. Outputs stay stable until rsp_valid&&rsp_ready at the edge, then go to IDLE.
- Timeout counter:
  - Cleared when entering A_SEND; increments every cycle in A_SEND or D_WAIT.
  - When the count equals TIMEOUT-1 and no A/D completion occurs that edge, go to RSP with err=1 and rsp_rdata=0. This drops a_valid, which is an intentional abort.
- Stray D beats: d_ready is also 1 in IDLE. Beats arriving in IDLE are consumed and discarded. d_ready=0 in A_SEND and RSP.
- Only one transaction is outstanding; no new request is accepted until the response handshake completes.
- Reset values: req_ready=0 during reset and 1 after it (IDLE). All other outputs are 0, including a_opcode=0 and d_ready=0 during reset.

## Timing
- Request accepted at edge N → a_valid high from N+1.
- a_ready high at edge N+1 → D_WAIT from N+1, d_ready high.
- D beat at edge N+1+k → rsp_valid high from the next cycle.
- Minimum request-to-rsp_valid latency is 3 cycles (with k=1). Back-to-back throughput is 1 transaction per 4 cycles.
- All outputs are registered or decoded from the state register only; no combinational path from inputs to outputs.
- If a D completion and the timeout fall on the same edge, the completion wins (err=0).
- Async reset mid-transaction aborts it immediately: a_valid and rsp_valid drop and the FSM returns to IDLE. No response is produced.

## Test plan
- Write addr 3, mask F, data 0xDEADBEEF; a_ready=1, d_valid with d_opcode=0 after 2 cycles → A beat shows opcode 0, mask F, addr 3, data DEADBEEF; rsp_valid with err=0, rdata=0.
- Write mask 4'b0011 → a_opcode=1. Read addr 5 with slave returning d_opcode=1, d_data=0x12345678 → a_opcode=4, a_data=0; rsp_rdata=0x12345678, err=0.
- a_ready held low 3 cycles → a_valid and the A fields stay stable for 4 cycles; handshake happens on the first edge a_ready is high.
- TIMEOUT=8 with the slave never raising d_valid → rsp_valid with err=1, rdata=0, exactly 8 cycles after entering A_SEND. A stray D beat afterwards in IDLE is consumed with no response.
- Read answered with d_opcode=0 → err=1, rdata=0. Then hold rsp_ready low 5 cycles → rsp_* stay stable and req_ready stays 0.
- Assert rst_n low while in D_WAIT → all outputs go to their reset values asynchronously. After release, req_ready=1 and a new write completes normally.

Source files
------------

// File: rtl/tl_ul_master.sv
// tl_ul_master
// Single-outstanding TileLink-UL initiator. A host command (read/write,
// 4-bit address, byte mask, 32-bit data) is turned into one channel-A
// request, and the matching channel-D beat becomes a host response. A
// response timeout stops a hung slave from stalling the host.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        host command handshake (ready only in IDLE)
//   req_write/addr/mask/wdata  host command fields
//   rsp_valid/rsp_ready        host response handshake (held until accepted)
//   rsp_rdata, rsp_err         response payload (rdata 0 for writes/errors)
//   a_valid/a_ready            channel-A handshake
//   a_opcode/mask/address/data channel-A payload (registered)
//   d_valid/d_ready            channel-D handshake (ready in IDLE and D_WAIT)
//   d_opcode, d_data           channel-D payload
//
// Every output comes straight from a flop. The handshake flags are loaded
// from the next-state decode, so they match the state register one cycle
// later without any path from inputs to outputs.
module tl_ul_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [3:0]  req_addr,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [3:0]  a_opcode,
  output logic [3:0]  a_mask,
  output logic [3:0]  a_address,
  output logic [31:0] a_data,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [3:0]  d_opcode,
  input  logic [31:0] d_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_SEND = 2'd1,
    D_WAIT = 2'd2,
    RSP    = 2'd3
  } state_e;

  localparam logic [3:0] OP_PUT_FULL    = 4'd0;
  localparam logic [3:0] OP_PUT_PARTIAL = 4'd1;
  localparam logic [3:0] OP_GET         = 4'd4;
  localparam logic [3:0] OP_ACK         = 4'd0;
  localparam logic [3:0] OP_ACK_DATA    = 4'd1;
  localparam logic [7:0] TIMEOUT_LAST   = 8'(TIMEOUT - 32'd1);

  state_e      state_r;
  state_e      state_s;
  logic        write_r;
  logic [7:0]  cnt_r;
  logic        req_ready_r;
  logic        a_valid_r;
  logic        d_ready_r;
  logic        rsp_valid_r;
  logic        rsp_err_r;
  logic [31:0] rsp_rdata_r;
  logic [3:0]  a_opcode_r;
  logic [3:0]  a_mask_r;
  logic [3:0]  a_address_r;
  logic [31:0] a_data_r;

  logic        accept_s;
  logic        a_hs_s;
  logic        d_hs_s;
  logic        rsp_hs_s;
  logic        timeout_s;
  logic        d_match_s;
  logic        to_err_s;

  // Handshake, timeout and response-pairing decode.
  always_comb begin
    accept_s  = req_ready_r && req_valid;
    a_hs_s    = (state_r == A_SEND) && a_valid_r && a_ready;
    d_hs_s    = (state_r == D_WAIT) && d_ready_r && d_valid;
    rsp_hs_s  = (state_r == RSP) && rsp_valid_r && rsp_ready;
    // '>=' rather than '==' so an A handshake on the deadline edge still
    // times out in D_WAIT instead of waiting for the counter to wrap.
    timeout_s = ((state_r == A_SEND) || (state_r == D_WAIT)) &&
                (cnt_r >= TIMEOUT_LAST);
    if (write_r) begin
      d_match_s = (d_opcode == OP_ACK);
    end else begin
      d_match_s = (d_opcode == OP_ACK_DATA);
    end
    // A completion on the deadline edge wins over the timeout.
    to_err_s  = timeout_s && !a_hs_s && !d_hs_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = A_SEND;
        else          state_s = IDLE;
      end
      A_SEND: begin
        if (a_hs_s)         state_s = D_WAIT;
        else if (to_err_s)  state_s = RSP;
        else                state_s = A_SEND;
      end
      D_WAIT: begin
        if (d_hs_s || to_err_s) state_s = RSP;
        else                    state_s = D_WAIT;
      end
      RSP: begin
        if (rsp_hs_s) state_s = IDLE;
        else          state_s = RSP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and registered handshake flags (from next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b0;
      a_valid_r   <= 1'b0;
      d_ready_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      req_ready_r <= (state_s == IDLE);
      a_valid_r   <= (state_s == A_SEND);
      d_ready_r   <= (state_s == IDLE) || (state_s == D_WAIT);
      rsp_valid_r <= (state_s == RSP);
    end
  end

  // Command capture into the channel-A registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_r     <= 1'b0;
      a_opcode_r  <= 4'd0;
      a_mask_r    <= 4'd0;
      a_address_r <= 4'd0;
      a_data_r    <= 32'd0;
    end else if (accept_s) begin
      write_r     <= req_write;
      a_mask_r    <= req_mask;
      a_address_r <= req_addr;
      if (!req_write) begin
        a_opcode_r <= OP_GET;
        a_data_r   <= 32'd0;
      end else if (req_mask == 4'hF) begin
        a_opcode_r <= OP_PUT_FULL;
        a_data_r   <= req_wdata;
      end else begin
        a_opcode_r <= OP_PUT_PARTIAL;
        a_data_r   <= req_wdata;
      end
    end
  end

  // Timeout counter: restarts on acceptance, saturates while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else if (accept_s) begin
      cnt_r <= 8'd0;
    end else if (((state_r == A_SEND) || (state_r == D_WAIT)) && (cnt_r != 8'hFF)) begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

  // Response capture from the D beat or the timeout abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'd0;
    end else if (d_hs_s) begin
      rsp_err_r   <= !d_match_s;
      rsp_rdata_r <= (d_match_s && !write_r) ? d_data : 32'd0;
    end else if (to_err_s) begin
      rsp_err_r   <= 1'b1;
      rsp_rdata_r <= 32'd0;
    end
  end

  assign req_ready = req_ready_r;
  assign a_valid   = a_valid_r;
  assign d_ready   = d_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign a_opcode  = a_opcode_r;
  assign a_mask    = a_mask_r;
  assign a_address = a_address_r;
  assign a_data    = a_data_r;

endmodule

// File: tb/tb_tl_ul_master.sv
// Testbench for tl_ul_master: a table of directed transactions, a few
// hand-written sequences (stray D beat, async reset mid-transaction) and
// randomized transactions checked against a transaction-level model.
module tb_tl_ul_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [3:0]  req_addr, req_mask;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        a_valid, a_ready;
  logic [3:0]  a_opcode, a_mask, a_address;
  logic [31:0] a_data;
  logic        d_valid, d_ready;
  logic [3:0]  d_opcode;
  logic [31:0] d_data;

  int checks = 0;
  int errors = 0;
  string cur_tag = "init";

  always #5 clk = ~clk;

  tl_ul_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_mask(req_mask), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_mask(a_mask), .a_address(a_address), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_data(d_data)
  );

  typedef struct {
    bit          write;
    logic [3:0]  addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          a_wait;
    int          d_wait;
    logic [3:0]  d_opc;
    logic [31:0] d_dat;
    int          rsp_wait;
    logic [3:0]  exp_opcode;
    logic [31:0] exp_adata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s actual=%h required=%h", cur_tag, name, act, exp);
    end
  endtask

  // Transaction-level reference: the D beat lands 2+a+d edges after
  // acceptance; the request is abandoned if that is past the deadline.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   timed_out;
    bit   bad_pair;
    r = v;
    timed_out    = (2 + v.a_wait + v.d_wait) > TO;
    r.exp_lat    = timed_out ? TO : 2 + v.a_wait + v.d_wait;
    r.exp_opcode = !v.write ? 4'd4 : ((v.mask == 4'hF) ? 4'd0 : 4'd1);
    r.exp_adata  = v.write ? v.wdata : 32'd0;
    bad_pair     = v.write ? (v.d_opc != 4'd0) : (v.d_opc != 4'd1);
    r.exp_err    = timed_out || bad_pair;
    r.exp_rdata  = (!r.exp_err && !v.write) ? v.d_dat : 32'd0;
    return r;
  endfunction

  task automatic check_reset_outs();
    chk("rst_ctrl", {22'd0, req_ready, d_ready, a_valid, rsp_valid, rsp_err, 1'b0, a_opcode}, 32'd0);
    chk("rst_a", {24'd0, a_mask, a_address}, 32'd0);
    chk("rst_adata", a_data, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
  endtask

  // Drive one transaction, play the slave, and check the response.
  task automatic run_txn(input vec_t v);
    int t = 0;
    int a_cnt = 0;
    int d_cnt = 0;
    bit a_done = 1'b0;
    bit hs;
    bit a_bad = 1'b0;
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
    req_mask = v.mask; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = $urandom; req_addr = $urandom; req_mask = $urandom; req_wdata = $urandom;
    chk("a_valid_up", {31'd0, a_valid}, 32'd1);
    while (rsp_valid !== 1'b1 && t < 40) begin
      if (a_valid === 1'b1) begin
        if (a_opcode !== v.exp_opcode || a_mask !== v.mask ||
            a_address !== v.addr || a_data !== v.exp_adata) a_bad = 1'b1;
        a_ready = (a_cnt == v.a_wait);
        a_cnt++;
      end else begin
        a_ready = 1'b0;
      end
      if (a_done && d_ready === 1'b1) begin
        d_valid  = (d_cnt == v.d_wait);
        d_opcode = d_valid ? v.d_opc : 4'($urandom);
        d_data   = d_valid ? v.d_dat : $urandom;
        d_cnt++;
      end else begin
        d_valid = 1'b0;
      end
      hs = (a_valid === 1'b1) && a_ready;
      @(posedge clk); #1;
      t++;
      if (hs) a_done = 1'b1;
    end
    a_ready = 1'b0; d_valid = 1'b0;
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("latency", t, v.exp_lat);
    chk("a_fields", {31'd0, a_bad}, 32'd0);
    chk("a_cycles", a_cnt, v.a_wait + 1);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_ctrl", {29'd0, req_ready, a_valid, d_ready}, 32'd0);
    for (int i = 0; i < v.rsp_wait; i++) begin
      @(posedge clk); #1;
      chk("hold_ctrl", {29'd0, rsp_valid, req_ready, rsp_err}, {29'd0, 1'b1, 1'b0, v.exp_err});
      chk("hold_rdata", rsp_rdata, v.exp_rdata);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_done", {29'd0, rsp_valid, req_ready, d_ready}, 32'd3);
  endtask

  vec_t vecs[10];
  vec_t rv;

  initial begin
    vecs[0] = '{1'b1, 4'h3, 4'hF, 32'hDEADBEEF, 0, 2,  4'd0, 32'h11111111, 0, 4'd0, 32'hDEADBEEF, 1'b0, 32'h0,        4};
    vecs[1] = '{1'b1, 4'h1, 4'h3, 32'h000000AA, 0, 0,  4'd0, 32'h00000022, 1, 4'd1, 32'h000000AA, 1'b0, 32'h0,        2};
    vecs[2] = '{1'b0, 4'h5, 4'hF, 32'h55555555, 0, 0,  4'd1, 32'h12345678, 0, 4'd4, 32'h0,        1'b0, 32'h12345678, 2};
    vecs[3] = '{1'b1, 4'h7, 4'hF, 32'hA5A5A5A5, 3, 0,  4'd0, 32'h0,        2, 4'd0, 32'hA5A5A5A5, 1'b0, 32'h0,        5};
    vecs[4] = '{1'b0, 4'h2, 4'h6, 32'hFFFFFFFF, 0, 0,  4'd0, 32'hCAFEF00D, 5, 4'd4, 32'h0,        1'b1, 32'h0,        2};
    vecs[5] = '{1'b1, 4'h9, 4'hF, 32'h01020304, 0, 20, 4'd0, 32'h0,        0, 4'd0, 32'h01020304, 1'b1, 32'h0,        8};
    vecs[6] = '{1'b1, 4'h4, 4'h8, 32'h0BADCAFE, 1, 0,  4'd1, 32'h00000033, 0, 4'd1, 32'h0BADCAFE, 1'b1, 32'h0,        3};
    vecs[7] = '{1'b0, 4'hA, 4'h1, 32'h0,        3, 3,  4'd1, 32'h89ABCDEF, 0, 4'd4, 32'h0,        1'b0, 32'h89ABCDEF, 8};
    vecs[8] = '{1'b0, 4'hB, 4'hF, 32'h0,        3, 4,  4'd1, 32'h00000077, 0, 4'd4, 32'h0,        1'b1, 32'h0,        8};
    vecs[9] = '{1'b0, 4'hC, 4'h0, 32'h13572468, 0, 0,  4'hF, 32'h00000044, 1, 4'd4, 32'h0,        1'b1, 32'h0,        2};

    rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 4'd0;
    req_mask = 4'd0; req_wdata = 32'd0; rsp_ready = 1'b0; a_ready = 1'b0;
    d_valid = 1'b0; d_opcode = 4'd0; d_data = 32'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cur_tag = "reset";
    check_reset_outs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset", {30'd0, req_ready, d_ready}, 32'd3);

    for (int i = 0; i < 10; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_txn(vecs[i]);
    end

    // Stray D beat in IDLE is swallowed without a response.
    cur_tag = "stray_d";
    d_valid = 1'b1; d_opcode = 4'd1; d_data = 32'h5A5A5A5A;
    chk("d_ready_idle", {31'd0, d_ready}, 32'd1);
    @(posedge clk); #1;
    d_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("no_rsp", {29'd0, rsp_valid, a_valid, req_ready}, 32'd1);
      @(posedge clk); #1;
    end

    // Async reset while in D_WAIT aborts the transaction.
    cur_tag = "mid_reset";
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'h6; req_mask = 4'hF; req_wdata = 32'hFEEDFACE;
    @(posedge clk); #1;
    req_valid = 1'b0; a_ready = 1'b1;
    @(posedge clk); #1;
    a_ready = 1'b0;
    chk("in_d_wait", {30'd0, d_ready, a_valid}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_back", {30'd0, req_ready, rsp_valid}, 32'd2);
    cur_tag = "after_reset";
    run_txn(vecs[0]);

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      cur_tag = $sformatf("rand%0d", i);
      rv.write    = $urandom_range(0, 1);
      rv.addr     = 4'($urandom);
      rv.mask     = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      rv.wdata    = $urandom;
      rv.a_wait   = $urandom_range(0, 5);
      rv.d_wait   = $urandom_range(0, 4);
      rv.d_opc    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : (rv.write ? 4'd0 : 4'd1);
      rv.d_dat    = $urandom;
      rv.rsp_wait = $urandom_range(0, 3);
      run_txn(model(rv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
